// File: rtl/vel_loop_if.sv
// Bus between the velocity-loop sequencer and its environment: run control,
// measurement handshake, velocity command and status flags.
interface vel_loop_if;
  logic              enable;
  logic signed [8:0] setpoint;
  logic signed [8:0] meas_vel;
  logic              meas_valid;
  logic              clr_fault;
  logic signed [8:0] out_vel;
  logic              out_valid;
  logic              sample_req;
  logic              fault;
  logic              overrun;
  logic              sat;

  modport master (
    output enable, setpoint, meas_vel, meas_valid, clr_fault,
    input  out_vel, out_valid, sample_req, fault, overrun, sat
  );
  modport slave (
    input  enable, setpoint, meas_vel, meas_valid, clr_fault,
    output out_vel, out_valid, sample_req, fault, overrun, sat
  );
endinterface

// File: rtl/vel_loop_sequencer.sv
// Velocity-loop sequencer: per sample tick it fetches a measurement, forms a
// rate-limited step toward the setpoint and emits a saturated velocity command.
module vel_loop_sequencer #(
  parameter int SAMPLE_DIV   = 1000,
  parameter int MEAS_TIMEOUT = 64,
  parameter int STEP_MAX     = 16,
  parameter int VMAX         = 255
) (
  input logic     CLK,
  input logic     RST_N,
  vel_loop_if.slave bus
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_TICK = 3'd1;
  localparam logic [2:0] S_WAIT_MEAS = 3'd2;
  localparam logic [2:0] S_COMPUTE   = 3'd3;
  localparam logic [2:0] S_UPDATE    = 3'd4;

  localparam logic [15:0]       DIV_M1 = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0]       TMO_M1 = 16'(MEAS_TIMEOUT - 1);
  localparam logic signed [9:0] STEP_P = 10'(STEP_MAX);
  localparam logic signed [9:0] STEP_N = -STEP_P;
  localparam logic signed [9:0] VMAX_P = 10'(VMAX);
  localparam logic signed [9:0] VMAX_N = -VMAX_P;

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       tmo_q, tmo_d;
  logic signed [8:0] sp_q, sp_d, mv_q, mv_d;
  logic signed [9:0] step_q, step_d;
  logic signed [8:0] out_vel_q, out_vel_d;
  logic              out_valid_q, out_valid_d;
  logic              fault_q, fault_d, overrun_q, overrun_d, sat_q, sat_d;

  logic              tick, ovr_ev, flt_ev;
  logic signed [9:0] err, step_c, sum, sum_c;

  always_comb begin
    tick   = bus.enable && (state_q != S_IDLE) && (cnt_q == DIV_M1);
    // A tick that lands outside WAIT_TICK means the loop missed a sample.
    ovr_ev = tick && ((state_q == S_WAIT_MEAS) || (state_q == S_COMPUTE) ||
                      (state_q == S_UPDATE));
    flt_ev = 1'b0;

    err = {sp_q[8], sp_q} - {mv_q[8], mv_q};
    if (err > STEP_P)      step_c = STEP_P;
    else if (err < STEP_N) step_c = STEP_N;
    else                   step_c = err;

    sum = {out_vel_q[8], out_vel_q} + step_q;
    if (sum > VMAX_P)      sum_c = VMAX_P;
    else if (sum < VMAX_N) sum_c = VMAX_N;
    else                   sum_c = sum;

    state_d     = state_q;
    cnt_d       = (!bus.enable || state_q == S_IDLE) ? 16'd0 :
                  (tick ? 16'd0 : cnt_q + 16'd1);
    tmo_d       = tmo_q;
    sp_d        = sp_q;
    mv_d        = mv_q;
    step_d      = step_q;
    out_vel_d   = out_vel_q;
    out_valid_d = 1'b0;
    sat_d       = sat_q;

    if (!bus.enable) begin
      state_d   = S_IDLE;
      tmo_d     = 16'd0;
      out_vel_d = '0;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_WAIT_TICK;
        S_WAIT_TICK: if (tick) begin
          state_d = S_WAIT_MEAS;
          tmo_d   = 16'd0;
        end
        S_WAIT_MEAS: begin
          // meas_valid beats a timeout expiring in the same cycle
          if (bus.meas_valid) begin
            sp_d    = bus.setpoint;
            mv_d    = bus.meas_vel;
            state_d = S_COMPUTE;
          end else if (tmo_q == TMO_M1) begin
            flt_ev      = 1'b1;
            out_vel_d   = '0;
            out_valid_d = 1'b1;
            sat_d       = 1'b0;
            state_d     = S_WAIT_TICK;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        S_COMPUTE: begin
          step_d  = step_c;
          state_d = S_UPDATE;
        end
        S_UPDATE: begin
          out_vel_d   = sum_c[8:0];
          sat_d       = (sum_c != sum);
          out_valid_d = 1'b1;
          state_d     = S_WAIT_TICK;
        end
        default:     state_d = S_IDLE;
      endcase
    end

    fault_d   = bus.clr_fault ? 1'b0 : fault_q;
    overrun_d = bus.clr_fault ? 1'b0 : overrun_q;
    if (flt_ev) fault_d   = 1'b1;
    if (ovr_ev) overrun_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      sp_q        <= '0;
      mv_q        <= '0;
      step_q      <= '0;
      out_vel_q   <= '0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      overrun_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      sp_q        <= sp_d;
      mv_q        <= mv_d;
      step_q      <= step_d;
      out_vel_q   <= out_vel_d;
      out_valid_q <= out_valid_d;
      fault_q     <= fault_d;
      overrun_q   <= overrun_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.out_vel    = out_vel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sample_req = (state_q == S_WAIT_MEAS);
  assign bus.fault      = fault_q;
  assign bus.overrun    = overrun_q;
  assign bus.sat        = sat_q;
endmodule

// File: doc/vel_loop_sequencer.md
VEL_LOOP_SEQUENCER -- requirements
Module: vel_loop_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1000, CLK cycles per velocity-loop sample period (legal range 8..65535).
REQ-002 SHALL have parameter MEAS_TIMEOUT, default 64, max CLK cycles spent waiting for a measurement after a sample tick.
REQ-003 SHALL have parameter STEP_MAX, default 16, max magnitude of the per-sample change in out_vel (1..255).
REQ-004 SHALL have parameter VMAX, default 255, saturation magnitude of out_vel (1..255).
REQ-005 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-007 SHALL have port enable  input  1  loop run request; low forces IDLE.
REQ-008 SHALL have port setpoint  input  9 signed  target velocity, sampled at capture.
REQ-009 SHALL have port meas_vel  input  9 signed  measured velocity from the speed estimator.
REQ-010 SHALL have port meas_valid  input  1  meas_vel qualifier, single-cycle or level.
REQ-011 SHALL have port clr_fault  input  1  clears the fault and overrun flags.
REQ-012 SHALL have port out_vel  output  9 signed registered velocity command to the commutation datapath.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse when out_vel updates.
REQ-014 SHALL have port sample_req  output  1  high while waiting for a measurement.
REQ-015 SHALL have ports fault, overrun, sat  output  1 each  sticky timeout flag, sticky missed-tick flag, last-update-saturated flag.

Function
REQ-016 SHALL implement states IDLE, WAIT_TICK, WAIT_MEAS, COMPUTE, UPDATE.
REQ-017 SHALL run a tick counter 0..SAMPLE_DIV-1 only while enable=1, wrapping to 0; tick asserts in the cycle count = SAMPLE_DIV-1.
REQ-018 IDLE -> WAIT_TICK when enable=1; the tick counter starts from 0 on that edge.
REQ-019 WAIT_TICK -> WAIT_MEAS on tick; a tick in any other non-IDLE state SHALL be dropped and set overrun.
REQ-020 In WAIT_MEAS, sample_req=1; meas_valid=1 SHALL capture meas_vel and setpoint on that edge (E) and go to COMPUTE.
REQ-021 meas_valid outside WAIT_MEAS SHALL be ignored.
REQ-022 COMPUTE SHALL register err = setpoint - meas_vel as 10-bit signed (no overflow), then step = err clamped to [-STEP_MAX, +STEP_MAX], and go to UPDATE at edge E+1.
REQ-023 UPDATE SHALL form sum = out_vel + step in 10-bit signed and clamp it to [-VMAX, +VMAX].
REQ-024 At edge E+2 out_vel SHALL take the clamped sum, out_valid SHALL be 1 for exactly one cycle, and sat SHALL be 1 iff clamping occurred; the state SHALL return to WAIT_TICK.
REQ-025 If WAIT_MEAS lasts MEAS_TIMEOUT cycles without meas_valid, the block SHALL set fault, force out_vel=0, pulse out_valid, and return to WAIT_TICK.
REQ-026 meas_valid in the same cycle as timeout expiry SHALL win: capture proceeds and no fault is raised.
REQ-027 enable=0 in any state SHALL go to IDLE on the next edge, clear the tick counter, set out_vel=0 with no out_valid, and abandon any in-flight computation.
REQ-028 clr_fault SHALL clear fault and overrun; a new fault or overrun event in the same cycle SHALL take priority and leave the flag set.
REQ-029 out_vel SHALL never leave [-VMAX, +VMAX] and SHALL change by no more than STEP_MAX per out_valid, except for forced zeroing.

Reset
REQ-030 RST_N=0 SHALL immediately, asynchronously, force state IDLE, counters 0, out_vel=0, out_valid=0, sample_req=0, fault=0, overrun=0, sat=0.
REQ-031 Reset release SHALL be synchronous to CLK; the first state change SHALL occur no earlier than the first rising edge with RST_N=1.
REQ-032 Reset asserted mid-COMPUTE or mid-UPDATE SHALL discard the computation with no out_valid pulse.

Verification (SAMPLE_DIV=8, MEAS_TIMEOUT=4, STEP_MAX=16, VMAX=200)
REQ-033 Apply reset with random inputs -> all outputs 0; release with enable=0 -> state stays IDLE, out_valid never pulses.
REQ-034 Set enable=1, setpoint=100, meas_vel=0, meas_valid=1 -> out_vel sequence 16,32,48,...,96, then 100 on later samples while meas_vel tracks out_vel; out_valid occurs 2 edges after each capture and sample_req occurs every 8 cycles.
REQ-035 Apply setpoint=255 with meas_vel=-256 held -> out_vel steps by 16 to 192, then 200 with sat=1, and stays at 200.
REQ-036 Hold meas_valid=0 after a tick -> after 4 cycles fault=1, out_vel=0, one out_valid pulse; then pulse clr_fault -> fault=0.
REQ-037 Hold meas_valid off for 7 cycles, then set it to 1 -> the tick falls in a non-WAIT_TICK state, overrun=1 (with MEAS_TIMEOUT raised to 16 for this case).
REQ-038 Drop enable during COMPUTE, and separately pulse RST_N low during UPDATE -> no out_valid pulse, out_vel=0, state IDLE.
